// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock synchronous FIFO controller with registered read data,
// occupancy count, full/empty flags, one-cycle overflow/underflow pulses and a
// sticky error flag.
module fifo_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  output logic                     udf_err,
  output logic                     err_sticky
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             sticky_q, sticky_d;

  logic             push_ok;
  logic             pop_ok;

  // Flags decode straight from the registered count.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));

  // A pop frees a slot in the same cycle, so a push at full is still accepted.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next-state for pointers, count, read data and error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    sticky_d = sticky_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d    = push & full & ~pop_ok;
    udf_d    = pop & empty;
    sticky_d = sticky_q | ovf_d | udf_d;
  end

  // Control and output registers; cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage array; not reset, stale entries are unreachable while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout       = dout_q;
  assign count      = count_q;
  assign ovf_err    = ovf_q;
  assign udf_err    = udf_q;
  assign err_sticky = sticky_q;

endmodule
